// File: rtl/kvs_req_arbiter_if.sv
// Request/response bundle between the two Ethernet ports, the arbiter and the KVS lookup engine.
// The master side drives requests and engine responses; the arbiter is the slave.
interface kvs_req_arbiter_if #(
    parameter int KEY_SIZE  = 96,
    parameter int DEPTH_LOG = 4
);
    logic                req0_valid;
    logic [KEY_SIZE-1:0] req0_key;
    logic [3:0]          req0_flag;
    logic                req0_ready;
    logic                req1_valid;
    logic [KEY_SIZE-1:0] req1_key;
    logic [3:0]          req1_flag;
    logic                req1_ready;
    logic                in_valid;
    logic [KEY_SIZE-1:0] in_key;
    logic [3:0]          in_flag;
    logic                out_valid;
    logic [3:0]          out_flag;
    logic                rsp0_valid;
    logic                rsp1_valid;
    logic [3:0]          rsp_flag;
    logic [DEPTH_LOG:0]  outstanding;
    logic                err_orphan;

    modport master (
        output req0_valid, req0_key, req0_flag, req1_valid, req1_key, req1_flag,
        output out_valid, out_flag,
        input  req0_ready, req1_ready, in_valid, in_key, in_flag,
        input  rsp0_valid, rsp1_valid, rsp_flag, outstanding, err_orphan
    );

    modport slave (
        input  req0_valid, req0_key, req0_flag, req1_valid, req1_key, req1_flag,
        input  out_valid, out_flag,
        output req0_ready, req1_ready, in_valid, in_key, in_flag,
        output rsp0_valid, rsp1_valid, rsp_flag, outstanding, err_orphan
    );
endinterface

// File: rtl/kvs_req_arbiter.sv
// Round-robin arbiter sharing the KVS lookup request port between ETH0/ETH1; a tag FIFO
// remembers the issuing port so in-order lookup responses are steered back to it.
module kvs_req_arbiter #(
    parameter int KEY_SIZE  = 96,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = 4
) (
    input  logic             clk,
    input  logic             rst,
    kvs_req_arbiter_if.slave bus
);
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);

    logic                 last;
    logic [DEPTH_LOG:0]   cnt;
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 tag_mem [DEPTH];
    logic                 full;
    logic                 empty;
    logic                 gnt0;
    logic                 gnt1;
    logic                 push;
    logic                 pop;
    logic                 head_id;

    logic                 vld_p1;
    logic [KEY_SIZE-1:0]  key_p1;
    logic [3:0]           flag_p1;
    logic                 rsp0_vld_p1;
    logic                 rsp1_vld_p1;
    logic [3:0]           rsp_flag_p1;
    logic                 orphan;

    // Stage p0: grant decision on the current occupancy; a pop this cycle cannot free a slot yet
    always_comb begin
        full    = (cnt == FULL_CNT);
        empty   = (cnt == '0);
        gnt0    = !full && bus.req0_valid && (!bus.req1_valid || last);
        gnt1    = !full && bus.req1_valid && (!bus.req0_valid || !last);
        push    = gnt0 || gnt1;
        pop     = bus.out_valid && !empty;
        head_id = tag_mem[rd_ptr];
    end

    // Stage p1: registered request toward the lookup engine
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            key_p1  <= '0;
            flag_p1 <= '0;
            last    <= 1'b1;
        end else begin
            vld_p1 <= push;
            if (gnt0) begin
                key_p1  <= bus.req0_key;
                flag_p1 <= bus.req0_flag;
            end else if (gnt1) begin
                key_p1  <= bus.req1_key;
                flag_p1 <= bus.req1_flag;
            end
            if (push) begin
                last <= gnt1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Stage p1: response steering; a response with no tag pending is an orphan
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_vld_p1 <= 1'b0;
            rsp1_vld_p1 <= 1'b0;
            rsp_flag_p1 <= '0;
            orphan      <= 1'b0;
        end else begin
            rsp0_vld_p1 <= pop && !head_id;
            rsp1_vld_p1 <= pop && head_id;
            if (pop) begin
                rsp_flag_p1 <= bus.out_flag;
            end
            if (bus.out_valid && empty) begin
                orphan <= 1'b1;
            end
        end
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.in_valid    = vld_p1;
    assign bus.in_key      = key_p1;
    assign bus.in_flag     = flag_p1;
    assign bus.rsp0_valid  = rsp0_vld_p1;
    assign bus.rsp1_valid  = rsp1_vld_p1;
    assign bus.rsp_flag    = rsp_flag_p1;
    assign bus.outstanding = cnt;
    assign bus.err_orphan  = orphan;
endmodule
